// File: rtl/cp0_int_ctrl.sv
// rtl/cp0_int_ctrl.sv - CP0 interrupt/exception sequencer: Status/Cause/EPC, vector redirect, eret return
module cp0_int_ctrl #(
    parameter int         NUM_INT   = 6,
    parameter logic [4:0] TRAP_CODE = 5'd12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_INT-1:0] INT,
    input  logic               trap,
    input  logic               eret,
    input  logic [31:0]        pc_current,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wd,
    output logic [31:0]        cp0_rd,
    output logic [1:0]         vec_sel,
    output logic               epc_sel,
    output logic [31:0]        epc,
    output logic               kill
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_HANDLER = 2'd1;
    localparam logic [1:0] ST_SHADOW  = 2'd2;

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] ADDR_EPC    = 5'd14;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [NUM_INT-1:0] int_meta;
    logic [NUM_INT-1:0] ip;
    logic [NUM_INT-1:0] im;
    logic               ie;
    logic               exl;
    logic [4:0]         exc_code;
    logic [31:0]        epc_q;

    logic               pend;
    logic               take_exc;
    logic               take_int;
    logic               handler_trap;
    logic               do_eret;
    logic [31:0]        status_word;
    logic [31:0]        cause_word;

    assign pend = (|(ip & im)) & ie & ~exl;

    // Trap always beats a pending interrupt and an eret in the same cycle.
    assign take_exc     = trap && (state == ST_RUN || state == ST_SHADOW);
    assign take_int     = pend && !trap && (state == ST_RUN);
    assign handler_trap = trap && (state == ST_HANDLER);
    assign do_eret      = eret && !trap && (state == ST_HANDLER);

    always_comb begin
        vec_sel = 2'b00;
        if (trap) begin
            vec_sel = 2'b10;
        end else if (take_int) begin
            vec_sel = 2'b11;
        end
    end

    assign kill    = trap | take_int;
    assign epc_sel = do_eret;
    assign epc     = epc_q;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (take_exc || take_int) begin
                    state_nxt = ST_HANDLER;
                end
            end
            ST_HANDLER: begin
                if (do_eret) begin
                    state_nxt = ST_SHADOW;
                end
            end
            ST_SHADOW: begin
                state_nxt = take_exc ? ST_HANDLER : ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            int_meta <= '0;
            ip       <= '0;
        end else begin
            state    <= state_nxt;
            int_meta <= INT;
            ip       <= int_meta;
        end
    end

    // Software writes first; later hardware updates override EXL/EPC/ExcCode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ie       <= 1'b0;
            exl      <= 1'b0;
            im       <= '0;
            exc_code <= 5'd0;
            epc_q    <= 32'd0;
        end else begin
            if (cp0_we) begin
                case (cp0_addr)
                    ADDR_STATUS: begin
                        ie  <= cp0_wd[0];
                        exl <= cp0_wd[1];
                        im  <= cp0_wd[10 +: NUM_INT];
                    end
                    ADDR_CAUSE: exc_code <= cp0_wd[6:2];
                    ADDR_EPC:   epc_q    <= cp0_wd;
                    default: ;
                endcase
            end
            if (take_exc || take_int) begin
                exl      <= 1'b1;
                epc_q    <= pc_current;
                exc_code <= take_exc ? TRAP_CODE : 5'd0;
            end
            if (handler_trap) begin
                exc_code <= TRAP_CODE;
            end
            if (do_eret) begin
                exl <= 1'b0;
            end
        end
    end

    always_comb begin
        status_word                  = 32'd0;
        status_word[0]               = ie;
        status_word[1]               = exl;
        status_word[10 +: NUM_INT]   = im;
        cause_word                   = 32'd0;
        cause_word[10 +: NUM_INT]    = ip;
        cause_word[6:2]              = exc_code;
    end

    always_comb begin
        case (cp0_addr)
            ADDR_STATUS: cp0_rd = status_word;
            ADDR_CAUSE:  cp0_rd = cause_word;
            ADDR_EPC:    cp0_rd = epc_q;
            default:     cp0_rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// tb/tb_cp0_int_ctrl.sv - scoreboard bench for cp0_int_ctrl
module tb_cp0_int_ctrl;

    localparam int K_VEC  = 0;
    localparam int K_EPCS = 1;
    localparam int K_KILL = 2;
    localparam int K_EPC  = 3;
    localparam int K_RD   = 4;

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  int_req;
    logic        trap;
    logic        eret;
    logic [31:0] pc_current;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wd;
    logic [31:0] cp0_rd;
    logic [1:0]  vec_sel;
    logic        epc_sel;
    logic [31:0] epc;
    logic        kill;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    cp0_int_ctrl #(.NUM_INT(6), .TRAP_CODE(5'd12)) dut (
        .clk        (clk),
        .rst        (rst),
        .INT        (int_req),
        .trap       (trap),
        .eret       (eret),
        .pc_current (pc_current),
        .cp0_we     (cp0_we),
        .cp0_addr   (cp0_addr),
        .cp0_wd     (cp0_wd),
        .cp0_rd     (cp0_rd),
        .vec_sel    (vec_sel),
        .epc_sel    (epc_sel),
        .epc        (epc),
        .kill       (kill)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        exp_q.push_back(e);
    endtask

    task automatic sample();
        exp_t        e;
        logic [31:0] obs;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_VEC:   obs = {30'd0, vec_sel};
                K_EPCS:  obs = {31'd0, epc_sel};
                K_KILL:  obs = {31'd0, kill};
                K_EPC:   obs = epc;
                default: obs = cp0_rd;
            endcase
            check_eq(e.tag, obs, e.exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        trap   = 1'b0;
        eret   = 1'b0;
        cp0_we = 1'b0;
        cp0_wd = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        cp0_we   = 1'b1;
        cp0_addr = addr;
        cp0_wd   = data;
    endtask

    initial begin
        rst        = 1'b0;
        int_req    = 6'd0;
        trap       = 1'b0;
        eret       = 1'b0;
        pc_current = 32'h40;
        cp0_we     = 1'b0;
        cp0_addr   = 5'd12;
        cp0_wd     = 32'd0;

        // reset state
        expect_out("rst_vec", K_VEC, 0);
        expect_out("rst_epcsel", K_EPCS, 0);
        expect_out("rst_kill", K_KILL, 0);
        expect_out("rst_epc", K_EPC, 0);
        expect_out("rst_status", K_RD, 0);
        sample();
        cp0_addr = 5'd13;
        expect_out("rst_cause", K_RD, 0);
        sample();

        next_cycle();
        rst = 1'b1;
        // interrupt take at 0x40 with IE=1, IM=000001
        next_cycle();
        mtc0(5'd12, 32'h0000_0401);
        expect_out("wr_status_vec", K_VEC, 0);
        sample();
        next_cycle();
        cp0_addr = 5'd12;
        int_req  = 6'b000001;
        expect_out("status_rd", K_RD, 32'h0000_0401);
        expect_out("sync_e0_vec", K_VEC, 0);
        sample();
        next_cycle();
        expect_out("sync_e1_vec", K_VEC, 0);
        sample();
        next_cycle();
        pc_current = 32'h40;
        expect_out("int_take_vec", K_VEC, 2'b11);
        expect_out("int_take_kill", K_KILL, 1);
        sample();
        next_cycle();
        pc_current = 32'h44;
        expect_out("hdl_epc", K_EPC, 32'h40);
        expect_out("hdl_status", K_RD, 32'h0000_0403);
        expect_out("hdl_vec", K_VEC, 0);
        expect_out("hdl_kill", K_KILL, 0);
        sample();
        cp0_addr = 5'd13;
        expect_out("hdl_cause", K_RD, 32'h0000_0400);
        sample();

        // eret -> shadow -> retake
        next_cycle();
        eret = 1'b1;
        expect_out("eret_epcsel", K_EPCS, 1);
        expect_out("eret_epc", K_EPC, 32'h40);
        expect_out("eret_kill", K_KILL, 0);
        expect_out("eret_vec", K_VEC, 0);
        sample();
        next_cycle();
        pc_current = 32'h44;
        expect_out("shadow_vec", K_VEC, 0);
        expect_out("shadow_kill", K_KILL, 0);
        sample();
        // retake, with mtc0 Status in the same cycle
        next_cycle();
        pc_current = 32'h48;
        mtc0(5'd12, 32'h0000_FC01);
        expect_out("retake_vec", K_VEC, 2'b11);
        expect_out("retake_kill", K_KILL, 1);
        sample();
        next_cycle();
        cp0_addr = 5'd12;
        expect_out("mtc0_take_status", K_RD, 32'h0000_FC03);
        expect_out("retake_epc", K_EPC, 32'h48);
        sample();

        // trap inside handler: ExcCode only
        next_cycle();
        pc_current = 32'h60;
        trap = 1'b1;
        expect_out("hdl_trap_vec", K_VEC, 2'b10);
        expect_out("hdl_trap_kill", K_KILL, 1);
        sample();
        next_cycle();
        cp0_addr = 5'd13;
        expect_out("hdl_trap_cause", K_RD, 32'h0000_0430);
        expect_out("hdl_trap_epc", K_EPC, 32'h48);
        sample();
        // eret together with trap: trap wins
        next_cycle();
        trap = 1'b1;
        eret = 1'b1;
        expect_out("eret_trap_vec", K_VEC, 2'b10);
        expect_out("eret_trap_epcsel", K_EPCS, 0);
        expect_out("eret_trap_kill", K_KILL, 1);
        sample();
        next_cycle();
        cp0_addr = 5'd12;
        expect_out("eret_trap_status", K_RD, 32'h0000_FC03);
        sample();

        // asynchronous reset mid-handler
        #2;
        rst = 1'b0;
        #1;
        check_eq("async_rst_epc", epc, 32'd0);
        check_eq("async_rst_status", cp0_rd, 32'd0);
        sample();

        // IM=0 with INT high: never taken, IP still visible
        next_cycle();
        rst = 1'b1;
        next_cycle();
        mtc0(5'd12, 32'h0000_0001);
        sample();
        next_cycle();
        eret = 1'b1;
        expect_out("run_eret_epcsel", K_EPCS, 0);
        expect_out("run_eret_vec", K_VEC, 0);
        sample();
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            cp0_addr = 5'd13;
            expect_out("im0_vec", K_VEC, 0);
            if (i >= 1) expect_out("im0_cause", K_RD, 32'h0000_0400);
            sample();
        end

        // trap with a pending interrupt at 0x80
        next_cycle();
        mtc0(5'd12, 32'h0000_0401);
        sample();
        next_cycle();
        pc_current = 32'h80;
        trap = 1'b1;
        expect_out("trap_pend_vec", K_VEC, 2'b10);
        expect_out("trap_pend_kill", K_KILL, 1);
        sample();
        next_cycle();
        cp0_addr = 5'd13;
        expect_out("trap_epc", K_EPC, 32'h80);
        expect_out("trap_cause", K_RD, 32'h0000_0430);
        sample();

        // trap in shadow behaves like RUN
        next_cycle();
        eret = 1'b1;
        sample();
        next_cycle();
        pc_current = 32'h90;
        trap = 1'b1;
        expect_out("shadow_trap_vec", K_VEC, 2'b10);
        sample();
        next_cycle();
        cp0_addr = 5'd12;
        expect_out("shadow_trap_epc", K_EPC, 32'h90);
        expect_out("shadow_trap_status", K_RD, 32'h0000_0403);
        sample();

        // mtc0 EPC, unmapped read
        next_cycle();
        mtc0(5'd14, 32'h0000_1234);
        sample();
        next_cycle();
        cp0_addr = 5'd14;
        expect_out("mtc0_epc_rd", K_RD, 32'h0000_1234);
        sample();
        cp0_addr = 5'd3;
        expect_out("unmapped_rd", K_RD, 0);
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
